reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 96 +++++++++
 tb/tb_reg_file.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register file with two combinational read ports,
// one write port and a per-register scoreboard busy bit.
// Optional feature: define REG_FILE_BYPASS_EN to forward the write port's
// data and busy clear onto a read port in the same cycle.
module reg_file #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Write,
    input  logic [ADDR_W-1:0] WAddr,
    input  logic [WIDTH-1:0]  I,
    input  logic [ADDR_W-1:0] RAddrA,
    input  logic [ADDR_W-1:0] RAddrB,
    output logic [WIDTH-1:0]  OA,
    output logic [WIDTH-1:0]  OB,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ResAddr,
    output logic              BusyA,
    output logic              BusyB
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]            busy_q, busy_d;

    // Register 0 is hardwired when ZERO_REG is set; it never stores data or busy.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic wr_ok, res_ok;
    assign wr_ok  = Write   && !is_zero_reg(WAddr);
    assign res_ok = Reserve && !is_zero_reg(ResAddr);

    // Next state: write clears busy, reservation sets it afterwards so set wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[WAddr] = I;
            busy_d[WAddr] = 1'b0;
        end
        if (res_ok) begin
            busy_d[ResAddr] = 1'b1;
        end
    end

    // State registers; reset overrides any write or reservation in the same cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    logic [WIDTH-1:0] rd_a, rd_b;
    logic             bs_a, bs_b;

    // Stored read data and busy bits; register 0 forced to zero explicitly.
    always_comb begin
        rd_a = is_zero_reg(RAddrA) ? '0 : regs_q[RAddrA];
        rd_b = is_zero_reg(RAddrB) ? '0 : regs_q[RAddrB];
        bs_a = is_zero_reg(RAddrA) ? 1'b0 : busy_q[RAddrA];
        bs_b = is_zero_reg(RAddrB) ? 1'b0 : busy_q[RAddrB];
    end

`ifdef REG_FILE_BYPASS_EN
    logic hit_a, hit_b;
    assign hit_a = wr_ok && (RAddrA == WAddr);
    assign hit_b = wr_ok && (RAddrB == WAddr);

    // Forward the in-flight write; busy shows only a same-cycle reservation.
    always_comb begin
        OA    = hit_a ? I : rd_a;
        OB    = hit_b ? I : rd_b;
        BusyA = hit_a ? (res_ok && (ResAddr == RAddrA)) : bs_a;
        BusyB = hit_b ? (res_ok && (ResAddr == RAddrB)) : bs_b;
    end
`else
    // No forwarding: outputs always reflect stored state.
    always_comb begin
        OA    = rd_a;
        OB    = rd_b;
        BusyA = bs_a;
        BusyB = bs_b;
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (WIDTH=16, ADDR_W=4, ZERO_REG=1).
module tb_reg_file;

    logic        CLK = 1'b0;
    logic        Reset, Write, Reserve;
    logic [3:0]  WAddr, RAddrA, RAddrB, ResAddr;
    logic [15:0] I, OA, OB;
    logic        BusyA, BusyB;

    int checks = 0;
    int errors = 0;

    reg_file #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1)) dut (
        .CLK(CLK), .Reset(Reset), .Write(Write), .WAddr(WAddr), .I(I),
        .RAddrA(RAddrA), .RAddrB(RAddrB), .OA(OA), .OB(OB),
        .Reserve(Reserve), .ResAddr(ResAddr), .BusyA(BusyA), .BusyB(BusyB)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [15:0] exp_byp;
        Reset = 1'b1; Write = 1'b0; Reserve = 1'b0;
        WAddr = '0; ResAddr = '0; RAddrA = '0; RAddrB = '0; I = '0;
        tick();
        Reset = 1'b0;

        // Post-reset: every address reads zero and not busy on both ports.
        for (int a = 0; a < 16; a++) begin
            RAddrA = 4'(a); RAddrB = 4'(15 - a);
            #1;
            chk($sformatf("rst_OA[%0d]", a), OA, 16'h0);
            chk($sformatf("rst_OB[%0d]", 15 - a), OB, 16'h0);
            chk($sformatf("rst_BusyA[%0d]", a), {15'b0, BusyA}, 16'h0);
            chk($sformatf("rst_BusyB[%0d]", 15 - a), {15'b0, BusyB}, 16'h0);
        end

        // Write r5; visible on both ports the cycle after.
        Write = 1'b1; WAddr = 4'd5; I = 16'h1234; RAddrA = 4'd5; RAddrB = 4'd5;
        tick();
        Write = 1'b0; #1;
        chk("r5_OA", OA, 16'h1234);
        chk("r5_OB", OB, 16'h1234);

        // Write to r0 is discarded.
        Write = 1'b1; WAddr = 4'd0; I = 16'hBEEF;
        tick();
        Write = 1'b0; RAddrA = 4'd0; #1;
        chk("r0_OA", OA, 16'h0000);

        // Ramp r[n] = n + 0x100, then read back pairs (n, 16-n).
        for (int n = 1; n < 16; n++) begin
            Write = 1'b1; WAddr = 4'(n); I = 16'(n + 16'h100);
            tick();
        end
        Write = 1'b0;
        for (int n = 1; n < 16; n++) begin
            RAddrA = 4'(n); RAddrB = 4'(16 - n);
            #1;
            chk($sformatf("ramp_OA[%0d]", n), OA, 16'(n + 16'h100));
            chk($sformatf("ramp_OB[%0d]", 16 - n), OB, 16'(16 - n + 16'h100));
        end

        // Reserve r3 -> busy; write r3 -> cleared with new data.
        Reserve = 1'b1; ResAddr = 4'd3;
        tick();
        Reserve = 1'b0; RAddrA = 4'd3; #1;
        chk("res_r3_BusyA", {15'b0, BusyA}, 16'h1);
        Write = 1'b1; WAddr = 4'd3; I = 16'h00AA;
        tick();
        Write = 1'b0; #1;
        chk("wr_r3_BusyA", {15'b0, BusyA}, 16'h0);
        chk("wr_r3_OA", OA, 16'h00AA);

        // Reserve and write r7 together: busy stays set, data written.
        Reserve = 1'b1; ResAddr = 4'd7; Write = 1'b1; WAddr = 4'd7; I = 16'h0077;
        tick();
        Reserve = 1'b0; Write = 1'b0; RAddrB = 4'd7; #1;
        chk("rw_r7_BusyB", {15'b0, BusyB}, 16'h1);
        chk("rw_r7_OB", OB, 16'h0077);

        // Reserve r2 while writing r6: both take effect. Reserve r0 never sets.
        Reserve = 1'b1; ResAddr = 4'd2; Write = 1'b1; WAddr = 4'd6; I = 16'h6666;
        tick();
        Reserve = 1'b1; ResAddr = 4'd0; Write = 1'b0;
        tick();
        Reserve = 1'b0; RAddrA = 4'd2; RAddrB = 4'd6; #1;
        chk("diff_r2_BusyA", {15'b0, BusyA}, 16'h1);
        chk("diff_r6_OB", OB, 16'h6666);
        chk("diff_r6_BusyB", {15'b0, BusyB}, 16'h0);
        RAddrA = 4'd0; #1;
        chk("r0_BusyA", {15'b0, BusyA}, 16'h0);

        // Write=0 leaves storage untouched.
        WAddr = 4'd6; I = 16'hFFFF;
        tick();
        chk("nowr_r6_OB", OB, 16'h6666);

        // Reset beats a simultaneous write and reservation; clears r7 busy too.
        Write = 1'b1; WAddr = 4'd9; I = 16'h5555;
        tick();
        Reset = 1'b1; Write = 1'b1; WAddr = 4'd9; I = 16'hAAAA;
        Reserve = 1'b1; ResAddr = 4'd9;
        tick();
        Reset = 1'b0; Write = 1'b0; Reserve = 1'b0;
        RAddrA = 4'd9; RAddrB = 4'd7; #1;
        chk("rst_r9_OA", OA, 16'h0);
        chk("rst_r9_BusyA", {15'b0, BusyA}, 16'h0);
        chk("rst_r7_OB", OB, 16'h0);
        chk("rst_r7_BusyB", {15'b0, BusyB}, 16'h0);

        // Same-cycle read of an in-flight write.
        Write = 1'b1; WAddr = 4'd4; I = 16'h1111;
        tick();
        Write = 1'b1; WAddr = 4'd4; I = 16'h2222; RAddrA = 4'd4; #1;
`ifdef REG_FILE_BYPASS_EN
        exp_byp = 16'h2222;
`else
        exp_byp = 16'h1111;
`endif
        chk("byp_same_OA", OA, exp_byp);
        tick();
        Write = 1'b0; #1;
        chk("byp_next_OA", OA, 16'h2222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
